// File: rtl/sdram_interface_pkg.sv
// Shared definitions for the SDRAM controller: pin command encodings, host
// command codes, mode register word and controller state encoding.
package sdram_interface_pkg;

   // {CS_N, RAS_N, CAS_N, WE_N}
   typedef enum logic [3:0] {
      CMD_LMR   = 4'b0000,
      CMD_REF   = 4'b0001,
      CMD_PRE   = 4'b0010,
      CMD_ACT   = 4'b0011,
      CMD_WRITE = 4'b0100,
      CMD_READ  = 4'b0101,
      CMD_NOP   = 4'b0111
   } sdram_cmd_e;

   typedef enum logic [1:0] {
      HCMD_NONE  = 2'b00,
      HCMD_READ  = 2'b01,
      HCMD_WRITE = 2'b10,
      HCMD_RSVD  = 2'b11
   } host_cmd_e;

   // Burst length 1, sequential, CAS latency 2.
   localparam logic [12:0] MODE_WORD = 13'h020;
   localparam logic [12:0] A10_ONLY  = 13'h400;

   typedef enum logic [3:0] {
      INIT_WAIT,
      INIT_PRE,
      INIT_REF1,
      INIT_REF2,
      INIT_LMR,
      IDLE,
      REFRESH,
      ACTIVATE,
      RW_WAIT,
      WRITE,
      READ,
      CAS_WAIT,
      RECOVER
   } state_e;

   // Column address with A10 set so every access auto-precharges.
   function automatic logic [12:0] col_addr(input logic [8:0] col);
      return {3'b001, 1'b0, col};
   endfunction

endpackage

// File: rtl/sdram_interface_if.sv
// Host-side command/response bus of the SDRAM controller.
interface sdram_interface_if;
   logic [1:0]  CMD_IN;
   logic [1:0]  BA_IN;
   logic [12:0] ROW_IN;
   logic [8:0]  COL_IN;
   logic [15:0] DATA_IN;
   logic        SDRAM_STATUS;
   logic [15:0] READ_DATA;
   logic        READ_VALID;

   modport master (
      output CMD_IN, BA_IN, ROW_IN, COL_IN, DATA_IN,
      input  SDRAM_STATUS, READ_DATA, READ_VALID
   );

   modport slave (
      input  CMD_IN, BA_IN, ROW_IN, COL_IN, DATA_IN,
      output SDRAM_STATUS, READ_DATA, READ_VALID
   );
endinterface

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh interval timer: raises due after T_REFI enabled cycles and
// holds there until cleared, so a late refresh never loses its request.
module sdram_refresh_timer #(
   parameter int T_REFI = 370
) (
   input  logic CLK_48MHZ,
   input  logic RESET,
   input  logic enable,
   input  logic clear,
   output logic due
);
   localparam int CW = $clog2(T_REFI + 1);
   localparam logic [CW-1:0] LIMIT = CW'(T_REFI);

   logic [CW-1:0] cnt;

   assign due = (cnt == LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK_48MHZ or posedge RESET) begin
      if (RESET) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !due) begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/sdram_interface.sv
// Single-word SDRAM controller: power-up init, periodic auto-refresh and
// auto-precharged read/write accesses. Assumes all waits >= 1 and CAS_LAT >= 1.
module sdram_interface
   import sdram_interface_pkg::*;
#(
   parameter int T_INIT  = 9600,
   parameter int T_REFI  = 370,
   parameter int T_RCD   = 1,
   parameter int T_RP    = 1,
   parameter int T_RFC   = 4,
   parameter int T_WR    = 2,
   parameter int CAS_LAT = 2
) (
   input  logic              CLK_48MHZ,
   input  logic              RESET,
   sdram_interface_if.slave  host,
   output logic              SDRAM_CKE,
   output logic              SDRAM_CS_N,
   output logic              SDRAM_RAS_N,
   output logic              SDRAM_CAS_N,
   output logic              SDRAM_WE_N,
   output logic [1:0]        SDRAM_BA,
   output logic [12:0]       SDRAM_A,
   output logic [1:0]        SDRAM_DQM,
   inout  wire  [15:0]       SDRAM_DQ
);
   localparam int CW = 16;
   localparam logic [CW-1:0] INIT_LAST = CW'(T_INIT - 1);
   localparam logic [CW-1:0] RP_N      = CW'(T_RP);
   localparam logic [CW-1:0] RFC_N     = CW'(T_RFC);
   localparam logic [CW-1:0] RCD_N     = CW'(T_RCD);
   localparam logic [CW-1:0] WREC_N    = CW'(T_WR + T_RP);
   localparam logic [CW-1:0] CL_LAST   = CW'(CAS_LAT - 1);
   localparam logic [CW-1:0] LMR_N     = CW'(2);

   state_e     state;
   logic [CW-1:0] wait_cnt;
   sdram_cmd_e cmd_q;
   logic       dq_oe;
   logic [15:0] dq_out;
   logic       status_q;
   logic [15:0] read_data_q;
   logic       read_valid_q;
   logic       init_done;
   logic       pending;
   host_cmd_e  op_cmd;
   logic [1:0] op_ba;
   logic [12:0] op_row;
   logic [8:0] op_col;
   logic [15:0] op_data;

   logic ref_due;
   logic ref_clear;
   logic cmd_valid;
   logic accept;
   logic [CW-1:0] rec_n;

   sdram_refresh_timer #(.T_REFI(T_REFI)) u_refresh_timer (
      .CLK_48MHZ (CLK_48MHZ),
      .RESET     (RESET),
      .enable    (init_done),
      .clear     (ref_clear),
      .due       (ref_due)
   );

   assign cmd_valid = (host.CMD_IN == HCMD_READ) || (host.CMD_IN == HCMD_WRITE);
   assign accept    = (state == IDLE) && !status_q && cmd_valid;
   assign ref_clear = (state == IDLE) && ref_due;
   assign rec_n     = (op_cmd == HCMD_WRITE) ? WREC_N : RP_N;

   assign {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N} = cmd_q;
   assign SDRAM_CKE = 1'b1;
   assign SDRAM_DQ  = dq_oe ? dq_out : 'z;

   assign host.SDRAM_STATUS = status_q;
   assign host.READ_DATA    = read_data_q;
   assign host.READ_VALID   = read_valid_q;

   always_ff @(posedge CLK_48MHZ or posedge RESET) begin
      if (RESET) begin
         state        <= INIT_WAIT;
         wait_cnt     <= '0;
         cmd_q        <= CMD_NOP;
         SDRAM_A      <= '0;
         SDRAM_BA     <= '0;
         SDRAM_DQM    <= 2'b11;
         dq_oe        <= 1'b0;
         dq_out       <= '0;
         status_q     <= 1'b1;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         init_done    <= 1'b0;
         pending      <= 1'b0;
         op_cmd       <= HCMD_NONE;
         op_ba        <= '0;
         op_row       <= '0;
         op_col       <= '0;
         op_data      <= '0;
      end else begin
         // NOTE: single-cycle outputs get a default here so each state only
         // names the cycle in which it issues something.
         cmd_q        <= CMD_NOP;
         dq_oe        <= 1'b0;
         read_valid_q <= 1'b0;
         wait_cnt     <= wait_cnt + 1'b1;

         case (state)
            INIT_WAIT: if (wait_cnt == INIT_LAST) begin
               cmd_q    <= CMD_PRE;
               SDRAM_A  <= A10_ONLY;
               wait_cnt <= '0;
               state    <= INIT_PRE;
            end
            INIT_PRE: if (wait_cnt == RP_N) begin
               cmd_q    <= CMD_REF;
               wait_cnt <= '0;
               state    <= INIT_REF1;
            end
            INIT_REF1: if (wait_cnt == RFC_N) begin
               cmd_q    <= CMD_REF;
               wait_cnt <= '0;
               state    <= INIT_REF2;
            end
            INIT_REF2: if (wait_cnt == RFC_N) begin
               cmd_q    <= CMD_LMR;
               SDRAM_A  <= MODE_WORD;
               SDRAM_BA <= 2'b00;
               wait_cnt <= '0;
               state    <= INIT_LMR;
            end
            INIT_LMR: if (wait_cnt == LMR_N) begin
               SDRAM_DQM <= 2'b00;
               init_done <= 1'b1;
               status_q  <= 1'b0;
               state     <= IDLE;
            end
            IDLE: begin
               if (accept) begin
                  op_cmd  <= host_cmd_e'(host.CMD_IN);
                  op_ba   <= host.BA_IN;
                  op_row  <= host.ROW_IN;
                  op_col  <= host.COL_IN;
                  op_data <= host.DATA_IN;
                  pending <= ref_due;
               end
               // Refresh wins; an accepted command waits as pending behind it.
               if (ref_due) begin
                  cmd_q    <= CMD_REF;
                  status_q <= 1'b1;
                  wait_cnt <= '0;
                  state    <= REFRESH;
               end else if (accept) begin
                  cmd_q    <= CMD_ACT;
                  SDRAM_BA <= host.BA_IN;
                  SDRAM_A  <= host.ROW_IN;
                  status_q <= 1'b1;
                  wait_cnt <= '0;
                  state    <= ACTIVATE;
               end
            end
            REFRESH: if (wait_cnt == RFC_N) begin
               if (pending) begin
                  cmd_q    <= CMD_ACT;
                  SDRAM_BA <= op_ba;
                  SDRAM_A  <= op_row;
                  pending  <= 1'b0;
                  wait_cnt <= '0;
                  state    <= ACTIVATE;
               end else begin
                  status_q <= 1'b0;
                  state    <= IDLE;
               end
            end
            ACTIVATE: state <= RW_WAIT;
            RW_WAIT: if (wait_cnt == RCD_N) begin
               SDRAM_A  <= col_addr(op_col);
               wait_cnt <= '0;
               if (op_cmd == HCMD_WRITE) begin
                  cmd_q  <= CMD_WRITE;
                  dq_oe  <= 1'b1;
                  dq_out <= op_data;
                  state  <= WRITE;
               end else begin
                  cmd_q  <= CMD_READ;
                  state  <= READ;
               end
            end
            WRITE: state <= RECOVER;
            READ, CAS_WAIT: begin
               // wait_cnt counts edges since READ left the pins.
               if (wait_cnt == CL_LAST) begin
                  read_data_q  <= SDRAM_DQ;
                  read_valid_q <= 1'b1;
                  wait_cnt     <= CW'(1);
                  state        <= RECOVER;
               end else begin
                  state <= CAS_WAIT;
               end
            end
            RECOVER: if (wait_cnt == rec_n) begin
               status_q <= 1'b0;
               state    <= IDLE;
            end
            default: state <= INIT_WAIT;
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_interface.sv
// Directed bench for sdram_interface: init sequence, write, read, refresh
// collision, reset during a read and ignored commands.
module tb_sdram_interface;

   localparam logic [3:0] P_NOP = 4'b0111;
   localparam logic [3:0] P_ACT = 4'b0011;
   localparam logic [3:0] P_RD  = 4'b0101;
   localparam logic [3:0] P_WR  = 4'b0100;
   localparam logic [3:0] P_PRE = 4'b0010;
   localparam logic [3:0] P_REF = 4'b0001;
   localparam logic [3:0] P_LMR = 4'b0000;

   logic        CLK_48MHZ = 1'b0;
   logic        RESET;
   logic        SDRAM_CKE, SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N;
   logic [1:0]  SDRAM_BA;
   logic [12:0] SDRAM_A;
   logic [1:0]  SDRAM_DQM;
   wire  [15:0] SDRAM_DQ;
   logic        tb_dq_oe;
   logic [15:0] tb_dq;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   sdram_interface_if bus ();

   sdram_interface #(
      .T_INIT (16),
      .T_REFI (60)
   ) dut (
      .CLK_48MHZ   (CLK_48MHZ),
      .RESET       (RESET),
      .host        (bus),
      .SDRAM_CKE   (SDRAM_CKE),
      .SDRAM_CS_N  (SDRAM_CS_N),
      .SDRAM_RAS_N (SDRAM_RAS_N),
      .SDRAM_CAS_N (SDRAM_CAS_N),
      .SDRAM_WE_N  (SDRAM_WE_N),
      .SDRAM_BA    (SDRAM_BA),
      .SDRAM_A     (SDRAM_A),
      .SDRAM_DQM   (SDRAM_DQM),
      .SDRAM_DQ    (SDRAM_DQ)
   );

   assign SDRAM_DQ = tb_dq_oe ? tb_dq : 'z;

   wire [3:0] pin_cmd = {SDRAM_CS_N, SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N};

   always #10 CLK_48MHZ = ~CLK_48MHZ;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Cycle n is the n-th clock period after RESET release, sampled 1 ns past its edge.
   task automatic step_to(input int n);
      while (cyc < n) begin
         @(posedge CLK_48MHZ);
         #1;
         cyc++;
      end
   endtask

   task automatic host_cmd(input logic [1:0] c, input logic [1:0] ba,
                           input logic [12:0] row, input logic [8:0] col,
                           input logic [15:0] data);
      bus.CMD_IN  = c;
      bus.BA_IN   = ba;
      bus.ROW_IN  = row;
      bus.COL_IN  = col;
      bus.DATA_IN = data;
   endtask

   task automatic check_init(input string pfx);
      step_to(15);
      check({pfx, " nop before pre"}, 32'(pin_cmd), 32'(P_NOP));
      step_to(16);
      check({pfx, " pre cmd"}, 32'(pin_cmd), 32'(P_PRE));
      check({pfx, " pre a10"}, 32'(SDRAM_A[10]), 32'd1);
      step_to(17);
      check({pfx, " nop after pre"}, 32'(pin_cmd), 32'(P_NOP));
      step_to(18);
      check({pfx, " ref1"}, 32'(pin_cmd), 32'(P_REF));
      step_to(23);
      check({pfx, " ref2"}, 32'(pin_cmd), 32'(P_REF));
      step_to(28);
      check({pfx, " lmr cmd"}, 32'(pin_cmd), 32'(P_LMR));
      check({pfx, " lmr word"}, 32'(SDRAM_A), 32'h020);
      step_to(30);
      check({pfx, " status busy last nop"}, 32'(bus.SDRAM_STATUS), 32'd1);
      step_to(31);
      check({pfx, " status idle"}, 32'(bus.SDRAM_STATUS), 32'd0);
      check({pfx, " idle nop"}, 32'(pin_cmd), 32'(P_NOP));
   endtask

   initial begin
      RESET    = 1'b1;
      tb_dq_oe = 1'b0;
      tb_dq    = 16'h0000;
      host_cmd(2'b00, 2'b00, 13'h0, 9'h0, 16'h0);

      repeat (2) @(posedge CLK_48MHZ);
      #1;
      check("rst status", 32'(bus.SDRAM_STATUS), 32'd1);
      check("rst pins nop", 32'(pin_cmd), 32'(P_NOP));
      check("rst a", 32'(SDRAM_A), 32'h0);
      check("rst ba", 32'(SDRAM_BA), 32'h0);
      check("rst dqm", 32'(SDRAM_DQM), 32'h3);
      check("rst read_data", 32'(bus.READ_DATA), 32'h0);
      check("rst read_valid", 32'(bus.READ_VALID), 32'h0);

      RESET = 1'b0;
      cyc   = 0;
      check_init("init");
      check("cke high", 32'(SDRAM_CKE), 32'd1);

      // Write; DATA_IN changes right after acceptance and must not leak through.
      host_cmd(2'b10, 2'b01, 13'h0123, 9'h045, 16'hBEEF);
      step_to(32);
      check("wr act cmd", 32'(pin_cmd), 32'(P_ACT));
      check("wr act ba", 32'(SDRAM_BA), 32'h1);
      check("wr act row", 32'(SDRAM_A), 32'h0123);
      check("wr busy", 32'(bus.SDRAM_STATUS), 32'd1);
      bus.DATA_IN = 16'hDEAD;
      step_to(33);
      check("wr rcd nop", 32'(pin_cmd), 32'(P_NOP));
      step_to(34);
      check("wr cmd", 32'(pin_cmd), 32'(P_WR));
      check("wr col", 32'(SDRAM_A), 32'h0445);
      check("wr dq", 32'(SDRAM_DQ), 32'hBEEF);
      check("wr dqm", 32'(SDRAM_DQM), 32'h0);
      step_to(35);
      check("wr recover nop", 32'(pin_cmd), 32'(P_NOP));
      step_to(37);
      check("wr busy while held cmd", 32'(bus.SDRAM_STATUS), 32'd1);
      check("wr held cmd ignored", 32'(pin_cmd), 32'(P_NOP));
      bus.CMD_IN = 2'b00;
      step_to(38);
      check("wr status falls", 32'(bus.SDRAM_STATUS), 32'd0);

      // Read back the same address; the bench plays the SDRAM data output.
      host_cmd(2'b01, 2'b01, 13'h0123, 9'h045, 16'h0000);
      step_to(39);
      check("rd act cmd", 32'(pin_cmd), 32'(P_ACT));
      check("rd act row", 32'(SDRAM_A), 32'h0123);
      bus.CMD_IN = 2'b00;
      step_to(41);
      check("rd cmd", 32'(pin_cmd), 32'(P_RD));
      check("rd col", 32'(SDRAM_A), 32'h0445);
      step_to(42);
      tb_dq    = 16'hBEEF;
      tb_dq_oe = 1'b1;
      check("rd valid early", 32'(bus.READ_VALID), 32'd0);
      step_to(43);
      check("rd valid", 32'(bus.READ_VALID), 32'd1);
      check("rd data", 32'(bus.READ_DATA), 32'hBEEF);
      step_to(44);
      tb_dq_oe = 1'b0;
      check("rd valid one cycle", 32'(bus.READ_VALID), 32'd0);
      check("rd data held", 32'(bus.READ_DATA), 32'hBEEF);
      check("rd status falls", 32'(bus.SDRAM_STATUS), 32'd0);

      // Refresh falls due on cycle 31+60; a command arrives on that very cycle.
      step_to(90);
      check("no early refresh", 32'(pin_cmd), 32'(P_NOP));
      step_to(91);
      check("idle before due", 32'(bus.SDRAM_STATUS), 32'd0);
      host_cmd(2'b10, 2'b10, 13'h0ABC, 9'h1FF, 16'h1234);
      step_to(92);
      check("coll ref first", 32'(pin_cmd), 32'(P_REF));
      bus.CMD_IN = 2'b00;
      for (int i = 92; i < 97; i++) begin
         step_to(i);
         check("coll status held", 32'(bus.SDRAM_STATUS), 32'd1);
      end
      step_to(97);
      check("coll act cmd", 32'(pin_cmd), 32'(P_ACT));
      check("coll act ba", 32'(SDRAM_BA), 32'h2);
      check("coll act row", 32'(SDRAM_A), 32'h0ABC);
      check("coll act status", 32'(bus.SDRAM_STATUS), 32'd1);
      step_to(99);
      check("coll wr cmd", 32'(pin_cmd), 32'(P_WR));
      check("coll wr col", 32'(SDRAM_A), 32'h05FF);
      check("coll wr dq", 32'(SDRAM_DQ), 32'h1234);
      step_to(103);
      check("coll status falls", 32'(bus.SDRAM_STATUS), 32'd0);

      // Read interrupted by reset while waiting for CAS latency.
      host_cmd(2'b01, 2'b10, 13'h0ABC, 9'h1FF, 16'h0000);
      step_to(104);
      check("abort act", 32'(pin_cmd), 32'(P_ACT));
      bus.CMD_IN = 2'b00;
      step_to(106);
      check("abort rd cmd", 32'(pin_cmd), 32'(P_RD));
      step_to(107);
      tb_dq    = 16'h5555;
      tb_dq_oe = 1'b1;
      RESET    = 1'b1;
      #1;
      check("abort pins nop", 32'(pin_cmd), 32'(P_NOP));
      check("abort status", 32'(bus.SDRAM_STATUS), 32'd1);
      check("abort a", 32'(SDRAM_A), 32'h0);
      check("abort ba", 32'(SDRAM_BA), 32'h0);
      check("abort dqm", 32'(SDRAM_DQM), 32'h3);
      check("abort read_data", 32'(bus.READ_DATA), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK_48MHZ);
         #1;
         check("abort no valid", 32'(bus.READ_VALID), 32'd0);
      end
      tb_dq_oe = 1'b0;
      RESET    = 1'b0;
      cyc      = 0;
      check_init("reinit");
      check("reinit read_data", 32'(bus.READ_DATA), 32'h0);

      // Reserved command in IDLE must be ignored.
      host_cmd(2'b11, 2'b01, 13'h0123, 9'h045, 16'hCAFE);
      for (int i = 32; i <= 34; i++) begin
         step_to(i);
         check("rsvd no act", 32'(pin_cmd), 32'(P_NOP));
         check("rsvd idle", 32'(bus.SDRAM_STATUS), 32'd0);
      end
      bus.CMD_IN = 2'b00;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
